// File: rtl/pipeline_ctrl_if.sv
// Control bundle between the MIPS datapath and its pipeline sequencer.
// No storage. Pure wiring, so it adds no latency.
// The datapath drives the hazard and memory inputs, and the sequencer returns the stage enables.
interface pipeline_ctrl_if;
    logic [31:0] id_instr;
    logic [5:0]  ex_op;
    logic [4:0]  ex_rt;
    logic        ex_taken;
    logic        mem_req;
    logic        mem_ready;
    logic        halt_req;
    logic        step;
    logic        pc_we;
    logic        ifid_we;
    logic        ifid_flush;
    logic        idex_we;
    logic        idex_bubble;
    logic        exmem_we;
    logic        memwb_we;

    // Datapath side: presents pipeline status and consumes the stage controls.
    modport master (
        output id_instr, ex_op, ex_rt, ex_taken, mem_req, mem_ready, halt_req, step,
        input  pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_we
    );

    // Sequencer side.
    modport slave (
        input  id_instr, ex_op, ex_rt, ex_taken, mem_req, mem_ready, halt_req, step,
        output pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_we
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: stage enables, load-use stall, branch flush, memory freeze, debug halt/step.
// Stage controls are combinational from state and inputs; state and counters update one cycle later.
// A pending data access (mem_req without mem_ready) freezes every stage until the memory completes.
module pipeline_ctrl #(
    parameter int CW           = 16,
    parameter bit START_HALTED = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    pipeline_ctrl_if.slave   pif,
    output logic [1:0]       state,
    output logic [CW-1:0]    lu_cnt,
    output logic [CW-1:0]    fl_cnt,
    output logic [CW-1:0]    fz_cnt
);
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_t;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;

    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    state_t cur_st;
    state_t nxt_st;
    logic   advance;
    logic   mem_block;
    logic   lu_hit;
    logic   rt_is_src;
    logic   unused_imm;

    logic [5:0] id_op;
    logic [4:0] id_rs;
    logic [4:0] id_rt;

    assign id_op      = pif.id_instr[31:26];
    assign id_rs      = pif.id_instr[25:21];
    assign id_rt      = pif.id_instr[20:16];
    assign unused_imm = ^pif.id_instr[15:0];
    assign state      = cur_st;

    // Load-use detection: a load in EX whose destination is read by the instruction in ID.
    // Only R-type, stores and branches read rt; for immediates rt is the destination.
    always_comb begin
        rt_is_src = (id_op == OP_R) || (id_op == OP_SW) ||
                    (id_op == OP_BEQ) || (id_op == OP_BNE);
        lu_hit    = (pif.ex_op == OP_LW) && (pif.ex_rt != 5'd0) &&
                    ((pif.ex_rt == id_rs) || ((pif.ex_rt == id_rt) && rt_is_src));
    end

    // Next-state and cycle class. "Stalled" for the halt check means frozen on memory.
    always_comb begin
        nxt_st    = cur_st;
        advance   = 1'b0;
        mem_block = pif.mem_req && !pif.mem_ready;
        case (cur_st)
            ST_RUN: begin
                if (mem_block) begin
                    nxt_st = ST_MEM_WAIT;
                end else begin
                    advance = 1'b1;
                    if (pif.halt_req) nxt_st = ST_HALT;
                end
            end
            ST_MEM_WAIT: begin
                if (pif.mem_ready) begin
                    advance = 1'b1;
                    nxt_st  = pif.halt_req ? ST_HALT : ST_RUN;
                end
            end
            ST_HALT: begin
                if (pif.step) begin
                    if (mem_block) nxt_st  = ST_MEM_WAIT;
                    else           advance = 1'b1;
                end else if (!pif.halt_req) begin
                    nxt_st = ST_RUN;
                end
            end
            default: nxt_st = ST_RUN;
        endcase
    end

    // Stage controls: everything off in reset or freeze; taken branch outranks load-use.
    always_comb begin
        pif.pc_we       = 1'b0;
        pif.ifid_we     = 1'b0;
        pif.ifid_flush  = 1'b0;
        pif.idex_we     = 1'b0;
        pif.idex_bubble = 1'b0;
        pif.exmem_we    = 1'b0;
        pif.memwb_we    = 1'b0;
        if (rst_n && advance) begin
            pif.pc_we    = 1'b1;
            pif.ifid_we  = 1'b1;
            pif.idex_we  = 1'b1;
            pif.exmem_we = 1'b1;
            pif.memwb_we = 1'b1;
            if (pif.ex_taken) begin
                pif.ifid_flush  = 1'b1;
                pif.idex_bubble = 1'b1;
            end else if (lu_hit) begin
                pif.pc_we       = 1'b0;
                pif.ifid_we     = 1'b0;
                pif.idex_bubble = 1'b1;
            end
        end
    end

    // State register and saturating event counters; reset drops any stall in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_st <= START_HALTED ? ST_HALT : ST_RUN;
            lu_cnt <= '0;
            fl_cnt <= '0;
            fz_cnt <= '0;
        end else begin
            cur_st <= nxt_st;
            if (advance && pif.ex_taken) begin
                if (fl_cnt != CNT_MAX) fl_cnt <= fl_cnt + CNT_ONE;
            end else if (advance && lu_hit) begin
                if (lu_cnt != CNT_MAX) lu_cnt <= lu_cnt + CNT_ONE;
            end
            if (!advance && fz_cnt != CNT_MAX) fz_cnt <= fz_cnt + CNT_ONE;
        end
    end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed vector table, counter saturation, then random against a model.
// Inputs change at the falling edge; controls are sampled 2 ns later and registers 1 ns after the rising edge.
// No backpressure applies to the bench itself.
module tb_pipeline_ctrl;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;
    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_JMP = 6'b000010,
                           OP_ADDI = 6'b001000, OP_ANDI = 6'b001100, OP_ORI = 6'b001101;
    // {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_we}
    localparam logic [6:0] C_FRZ = 7'b0000000, C_ADV = 7'b1101011,
                           C_LU = 7'b0001111, C_FL = 7'b1111111;

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0] state;
    logic [CW-1:0] lu_cnt, fl_cnt, fz_cnt;
    int n_checks = 0;
    int n_err = 0;

    pipeline_ctrl_if pif();

    pipeline_ctrl #(.CW(CW), .START_HALTED(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .pif(pif),
        .state(state), .lu_cnt(lu_cnt), .fl_cnt(fl_cnt), .fz_cnt(fz_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] instr;
        logic [5:0]  eop;
        logic [4:0]  ert;
        logic        tkn, mreq, mrdy, halt, stp;
        logic [6:0]  exp_ctl;
        int          exp_st, exp_lu, exp_fl, exp_fz;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic [31:0] instr, logic [5:0] eop, logic [4:0] ert,
                                logic tkn, logic mreq, logic mrdy, logic halt, logic stp,
                                logic [6:0] ctl, int st, int lu, int fl, int fz);
        vec_t v;
        v.rst = rst; v.instr = instr; v.eop = eop; v.ert = ert; v.tkn = tkn;
        v.mreq = mreq; v.mrdy = mrdy; v.halt = halt; v.stp = stp;
        v.exp_ctl = ctl; v.exp_st = st; v.exp_lu = lu; v.exp_fl = fl; v.exp_fz = fz;
        return v;
    endfunction

    function automatic logic [31:0] ins(logic [5:0] op, logic [4:0] rs, logic [4:0] rt);
        return {op, rs, rt, 16'h0000};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(logic rst, logic [31:0] instr, logic [5:0] eop, logic [4:0] ert,
                         logic tkn, logic mreq, logic mrdy, logic halt, logic stp);
        rst_n = rst; pif.id_instr = instr; pif.ex_op = eop; pif.ex_rt = ert;
        pif.ex_taken = tkn; pif.mem_req = mreq; pif.mem_ready = mrdy;
        pif.halt_req = halt; pif.step = stp;
    endtask

    function automatic logic [6:0] ctl_now();
        return {pif.pc_we, pif.ifid_we, pif.ifid_flush, pif.idex_we,
                pif.idex_bubble, pif.exmem_we, pif.memwb_we};
    endfunction

    // Load-use rule straight from the ISA: does ID read the register a load in EX is writing?
    function automatic bit lu_rule(logic [31:0] instr, logic [5:0] eop, logic [4:0] ert);
        logic [5:0] op = instr[31:26];
        bit reads_rt = (op == OP_R) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
        return (eop == OP_LW) && (ert != 5'd0) &&
               ((ert == instr[25:21]) || (reads_rt && ert == instr[20:16]));
    endfunction

    task automatic run_table();
        logic [31:0] nop = 32'h0;
        logic [31:0] add5 = ins(OP_R, 5'd5, 5'd0);
        logic [31:0] sw7 = ins(OP_SW, 5'd1, 5'd7);
        logic [31:0] addi7 = ins(OP_ADDI, 5'd1, 5'd7);
        //                rst instr  eop    ert  tk mq mr ht st  ctl    st lu fl fz
        tbl.push_back(mk(0, nop,   OP_R,  5'd0, 0, 0, 0, 0, 0, C_FRZ, 0, 0, 0, 0));
        tbl.push_back(mk(0, add5,  OP_LW, 5'd5, 1, 1, 0, 1, 1, C_FRZ, 0, 0, 0, 0));
        tbl.push_back(mk(1, nop,   OP_R,  5'd0, 0, 0, 0, 0, 0, C_ADV, 0, 0, 0, 0));
        tbl.push_back(mk(1, add5,  OP_LW, 5'd5, 0, 0, 0, 0, 0, C_LU,  0, 1, 0, 0));
        tbl.push_back(mk(1, add5,  OP_LW, 5'd0, 0, 0, 0, 0, 0, C_ADV, 0, 1, 0, 0));
        tbl.push_back(mk(1, add5,  OP_LW, 5'd5, 1, 0, 0, 0, 0, C_FL,  0, 1, 1, 0));
        tbl.push_back(mk(1, sw7,   OP_LW, 5'd7, 0, 0, 0, 0, 0, C_LU,  0, 2, 1, 0));
        tbl.push_back(mk(1, addi7, OP_LW, 5'd7, 0, 0, 0, 0, 0, C_ADV, 0, 2, 1, 0));
        tbl.push_back(mk(1, nop,   OP_R,  5'd0, 0, 1, 0, 0, 0, C_FRZ, 1, 2, 1, 1));
        tbl.push_back(mk(1, nop,   OP_R,  5'd0, 0, 1, 0, 0, 0, C_FRZ, 1, 2, 1, 2));
        tbl.push_back(mk(1, nop,   OP_R,  5'd0, 0, 1, 0, 0, 0, C_FRZ, 1, 2, 1, 3));
        tbl.push_back(mk(1, nop,   OP_R,  5'd0, 0, 1, 1, 0, 0, C_ADV, 0, 2, 1, 3));
        tbl.push_back(mk(1, nop,   OP_R,  5'd0, 0, 0, 0, 1, 0, C_ADV, 2, 2, 1, 3));
        tbl.push_back(mk(1, nop,   OP_R,  5'd0, 0, 0, 0, 1, 0, C_FRZ, 2, 2, 1, 4));
        tbl.push_back(mk(1, nop,   OP_R,  5'd0, 0, 0, 0, 1, 1, C_ADV, 2, 2, 1, 4));
        tbl.push_back(mk(1, nop,   OP_R,  5'd0, 0, 0, 0, 1, 0, C_FRZ, 2, 2, 1, 5));
        tbl.push_back(mk(1, nop,   OP_R,  5'd0, 0, 0, 0, 1, 1, C_ADV, 2, 2, 1, 5));
        tbl.push_back(mk(1, nop,   OP_R,  5'd0, 0, 0, 0, 1, 0, C_FRZ, 2, 2, 1, 6));
        tbl.push_back(mk(1, nop,   OP_R,  5'd0, 0, 0, 0, 0, 0, C_FRZ, 0, 2, 1, 7));
        tbl.push_back(mk(1, nop,   OP_R,  5'd0, 0, 0, 0, 0, 0, C_ADV, 0, 2, 1, 7));
        tbl.push_back(mk(1, nop,   OP_R,  5'd0, 0, 1, 0, 0, 0, C_FRZ, 1, 2, 1, 8));
        tbl.push_back(mk(0, nop,   OP_R,  5'd0, 0, 1, 0, 0, 0, C_FRZ, 0, 0, 0, 0));
        tbl.push_back(mk(1, nop,   OP_R,  5'd0, 0, 0, 0, 0, 0, C_ADV, 0, 0, 0, 0));
        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].instr, tbl[i].eop, tbl[i].ert, tbl[i].tkn,
                  tbl[i].mreq, tbl[i].mrdy, tbl[i].halt, tbl[i].stp);
            #2;
            check($sformatf("vec%0d_ctl", i), 32'(ctl_now()), 32'(tbl[i].exp_ctl));
            @(posedge clk); #1;
            check($sformatf("vec%0d_state", i), 32'(state), tbl[i].exp_st);
            check($sformatf("vec%0d_lu", i), 32'(lu_cnt), tbl[i].exp_lu);
            check($sformatf("vec%0d_fl", i), 32'(fl_cnt), tbl[i].exp_fl);
            check($sformatf("vec%0d_fz", i), 32'(fz_cnt), tbl[i].exp_fz);
            @(negedge clk);
        end
    endtask

    // Hold a load-use hazard well past the counter range; lu_cnt must pin at its maximum.
    task automatic run_saturation();
        for (int i = 0; i < CMAX + 1 + 5; i++) begin
            drive(1'b1, ins(OP_BEQ, 5'd2, 5'd9), OP_LW, 5'd9, 0, 0, 0, 0, 0);
            #2;
            check("sat_ctl", 32'(ctl_now()), 32'(C_LU));
            @(posedge clk); #1;
            @(negedge clk);
        end
        check("sat_lu", 32'(lu_cnt), CMAX);
        check("sat_fz", 32'(fz_cnt), 0);
    endtask

    task automatic run_random(int ncyc);
        bit m_halt = 1'b0, m_wait = 1'b0;
        int m_lu = 0, m_fl = 0, m_fz = 0;
        bit halt_lvl = 1'b0;
        logic [5:0] ops[9] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_JMP, OP_ADDI, OP_ANDI, OP_ORI};
        for (int i = 0; i < ncyc; i++) begin
            bit rst, tkn, mreq, mrdy, stp, blocked, adv, lu;
            logic [31:0] instr;
            logic [5:0] eop;
            logic [4:0] ert;
            logic [6:0] exp_ctl;
            int exp_st;
            if ($urandom_range(0, 7) == 0) halt_lvl = ~halt_lvl;
            rst   = (i == 0) ? 1'b0 : ($urandom_range(0, 39) != 0);
            instr = ins(ops[$urandom_range(0, 8)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            instr[15:0] = 16'($urandom);
            eop   = ($urandom_range(0, 1) == 1) ? OP_LW : ops[$urandom_range(0, 8)];
            ert   = 5'($urandom_range(0, 3));
            tkn   = ($urandom_range(0, 7) == 0);
            mreq  = ($urandom_range(0, 2) == 0);
            mrdy  = ($urandom_range(0, 1) == 1);
            stp   = ($urandom_range(0, 2) == 0);
            drive(rst, instr, eop, ert, tkn, mreq, mrdy, halt_lvl, stp);

            blocked = mreq && !mrdy;
            lu      = lu_rule(instr, eop, ert);
            if (m_wait)                adv = mrdy;
            else if (m_halt && !stp)   adv = 1'b0;
            else                       adv = !blocked;
            if (!rst || !adv)  exp_ctl = C_FRZ;
            else if (tkn)      exp_ctl = C_FL;
            else if (lu)       exp_ctl = C_LU;
            else               exp_ctl = C_ADV;
            #2;
            check("rnd_ctl", 32'(ctl_now()), 32'(exp_ctl));

            if (!rst) begin
                m_wait = 1'b0; m_halt = 1'b0; m_lu = 0; m_fl = 0; m_fz = 0;
            end else begin
                if (adv && tkn)      m_fl = (m_fl < CMAX) ? m_fl + 1 : CMAX;
                else if (adv && lu)  m_lu = (m_lu < CMAX) ? m_lu + 1 : CMAX;
                if (!adv)            m_fz = (m_fz < CMAX) ? m_fz + 1 : CMAX;
                if (m_wait) begin
                    if (mrdy) begin m_wait = 1'b0; m_halt = halt_lvl; end
                end else if (m_halt && !stp) begin
                    m_halt = halt_lvl;
                end else if (blocked) begin
                    m_wait = 1'b1;
                end else if (!m_halt) begin
                    m_halt = halt_lvl;
                end
            end
            exp_st = m_wait ? 1 : (m_halt ? 2 : 0);
            @(posedge clk); #1;
            check("rnd_state", 32'(state), exp_st);
            check("rnd_cnt", {8'h0, 8'(lu_cnt), 8'(fl_cnt), 8'(fz_cnt)},
                  {8'h0, 8'(m_lu), 8'(m_fl), 8'(m_fz)});
            @(negedge clk);
        end
    endtask

    initial begin
        drive(1'b0, 32'h0, OP_R, 5'd0, 0, 0, 0, 0, 0);
        run_table();
        run_saturation();
        run_random(3000);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
